hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 13 +
 rtl/hazard_detect.sv | 23 ++
 rtl/hazard_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] X0 = 5'd0;
    localparam int MD_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_ex,
    input  logic       mem_read_ex,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_used_id && (rs1_id == rd_ex);
    assign rs2_hit = rs2_used_id && (rs2_id == rd_ex);

    // x0 is never written, so a load targeting it cannot create a dependency
    assign load_use = mem_read_ex && (rd_ex != X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; resolves mem-wait, MUL/DIV, mispredict, load-use
//   MD_WAIT  | multi-cycle MUL/DIV occupies EX; front end frozen, bubble into MEM
//   MEM_WAIT | data memory stalled; whole pipeline frozen, bubble into WB
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             mem_read_ex,
    input  logic             mispredict_ex,
    input  logic             md_start_ex,
    input  logic             md_done,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int TO_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            set_timeout;
    logic            load_use;

    logic pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c, mem_wb_en_c;
    logic if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, mem_wb_flush_c;
    logic md_busy_c;

    hazard_detect u_detect (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .rd_ex       (rd_ex),
        .mem_read_ex (mem_read_ex),
        .load_use    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            to_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (set_timeout) begin
                md_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        to_cnt_nxt     = to_cnt;
        set_timeout    = 1'b0;
        md_busy_c      = 1'b0;
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        id_ex_en_c     = 1'b1;
        ex_mem_en_c    = 1'b1;
        mem_wb_en_c    = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        mem_wb_flush_c = 1'b0;

        case (state)
            RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    pc_en_c        = 1'b0;
                    if_id_en_c     = 1'b0;
                    id_ex_en_c     = 1'b0;
                    ex_mem_en_c    = 1'b0;
                    mem_wb_en_c    = 1'b0;
                    mem_wb_flush_c = 1'b1;
                    state_nxt      = MEM_WAIT;
                end else if (md_start_ex) begin
                    // a same-cycle md_done is a 0-cycle result: flow on untouched;
                    // any concurrent mispredict is dropped either way
                    if (!md_done) begin
                        pc_en_c        = 1'b0;
                        if_id_en_c     = 1'b0;
                        id_ex_en_c     = 1'b0;
                        ex_mem_flush_c = 1'b1;
                        state_nxt      = MD_WAIT;
                        to_cnt_nxt     = '0;
                    end
                end else if (mispredict_ex) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (load_use) begin
                    pc_en_c       = 1'b0;
                    if_id_en_c    = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end

            MD_WAIT: begin
                md_busy_c = 1'b1;
                if (md_done) begin
                    state_nxt = RUN;
                end else if (to_cnt == TO_LAST) begin
                    set_timeout    = 1'b1;
                    ex_mem_flush_c = 1'b1;
                    state_nxt      = RUN;
                end else begin
                    pc_en_c        = 1'b0;
                    if_id_en_c     = 1'b0;
                    id_ex_en_c     = 1'b0;
                    ex_mem_flush_c = 1'b1;
                    to_cnt_nxt     = to_cnt + 1'b1;
                end
            end

            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else begin
                    pc_en_c        = 1'b0;
                    if_id_en_c     = 1'b0;
                    id_ex_en_c     = 1'b0;
                    ex_mem_en_c    = 1'b0;
                    mem_wb_en_c    = 1'b0;
                    mem_wb_flush_c = 1'b1;
                end
            end

            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Reset forces every control low immediately, independent of the clock
    assign pc_en        = rst_n & pc_en_c;
    assign if_id_en     = rst_n & if_id_en_c;
    assign id_ex_en     = rst_n & id_ex_en_c;
    assign ex_mem_en    = rst_n & ex_mem_en_c;
    assign mem_wb_en    = rst_n & mem_wb_en_c;
    assign if_id_flush  = rst_n & if_id_flush_c;
    assign id_ex_flush  = rst_n & id_ex_flush_c;
    assign ex_mem_flush = rst_n & ex_mem_flush_c;
    assign mem_wb_flush = rst_n & mem_wb_flush_c;
    assign md_busy      = rst_n & md_busy_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // if_id_flush is raised only by a mispredict redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (if_id_flush_c && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic
// against a cycle-level behavioural model of the pipeline hazard rules.
module tb_hazard_ctrl;

    localparam int MD_TO = 64;
    localparam int CW    = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic          rs1_used_id = 0, rs2_used_id = 0, mem_read_ex = 0;
    logic          mispredict_ex = 0, md_start_ex = 0, md_done = 0;
    logic          dmem_req_mem = 0, dmem_ready = 1;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic          md_busy, md_timeout;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [9:0]    obs;

    hazard_ctrl #(.MD_TIMEOUT(MD_TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .mispredict_ex(mispredict_ex), .md_start_ex(md_start_ex), .md_done(md_done),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush | busy}
    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, md_busy};

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // model: memory-wait flag, MUL/DIV age (-1 = idle), sticky timeout, counters
    bit            m_mem = 0;
    int            m_age = -1;
    bit            m_to  = 0;
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    task automatic model_eval(output logic [9:0] e, output bit n_mem, output int n_age,
                              output bit n_to, output bit f_evt);
        logic [4:0] en;
        logic [3:0] fl;
        bit         busy, lu;
        en = 5'b11111; fl = 4'b0000; busy = 0;
        n_mem = m_mem; n_age = m_age; n_to = m_to; f_evt = 0;
        lu = mem_read_ex && rd_ex != 0 &&
             ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
        if (!rst_n) begin
            e = '0; n_mem = 0; n_age = -1; n_to = 0;
            return;
        end
        if (m_mem) begin
            if (dmem_ready) n_mem = 0;
            else begin en = 5'b00000; fl = 4'b0001; end
        end else if (m_age >= 0) begin
            busy = 1;
            if (md_done) n_age = -1;
            else if (m_age == MD_TO - 1) begin fl = 4'b0010; n_to = 1; n_age = -1; end
            else begin en = 5'b00011; fl = 4'b0010; n_age = m_age + 1; end
        end else if (dmem_req_mem && !dmem_ready) begin
            en = 5'b00000; fl = 4'b0001; n_mem = 1;
        end else if (md_start_ex) begin
            if (!md_done) begin en = 5'b00011; fl = 4'b0010; n_age = 0; end
        end else if (mispredict_ex) begin
            fl = 4'b1100; f_evt = 1;
        end else if (lu) begin
            en = 5'b00111; fl = 4'b0100;
        end
        e = {en, fl, busy};
    endtask

    task automatic tick(input string tag);
        logic [9:0] e;
        bit n_mem, n_to, f_evt;
        int n_age;
        @(negedge clk);
        model_eval(e, n_mem, n_age, n_to, f_evt);
        check(tag, 64'(obs), 64'(e));
        check({tag, "/md_timeout"}, 64'(md_timeout), 64'(m_to));
        check({tag, "/stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
        check({tag, "/flush_events"}, 64'(flush_events), 64'(m_flush));
        @(posedge clk);
        #1;
        m_mem = n_mem; m_age = n_age; m_to = n_to;
        if (!rst_n) begin
            m_stall = '0; m_flush = '0;
        end else if (PERF_EN) begin
            if (!e[9] && m_stall != '1) m_stall = m_stall + 1'b1;
            if (f_evt && m_flush != '1) m_flush = m_flush + 1'b1;
        end
    endtask

    task automatic idle_inputs();
        rs1_id = 0; rs2_id = 0; rd_ex = 0; rs1_used_id = 0; rs2_used_id = 0;
        mem_read_ex = 0; mispredict_ex = 0; md_start_ex = 0; md_done = 0;
        dmem_req_mem = 0; dmem_ready = 1;
    endtask

    initial begin
        // reset holds every control low even with a hazard present
        dmem_req_mem = 1; dmem_ready = 0;
        tick("in_reset");
        idle_inputs();
        tick("in_reset_idle");
        rst_n = 1;
        tick("run_defaults");

        // load-use through rs2, then clear
        mem_read_ex = 1; rd_ex = 5; rs2_used_id = 1; rs2_id = 5;
        tick("load_use_rs2");
        idle_inputs();
        tick("after_load_use");
        mem_read_ex = 1; rd_ex = 7; rs1_used_id = 1; rs1_id = 7;
        tick("load_use_rs1");
        mem_read_ex = 1; rd_ex = 0; rs1_used_id = 1; rs1_id = 0; rs2_used_id = 1; rs2_id = 0;
        tick("load_x0_no_stall");
        mem_read_ex = 1; rd_ex = 9; rs1_used_id = 0; rs1_id = 9; rs2_used_id = 0; rs2_id = 9;
        tick("load_unused_src");
        idle_inputs();

        // mispredict alone and with a concurrent load-use
        mispredict_ex = 1;
        tick("mispredict");
        mem_read_ex = 1; rd_ex = 5; rs2_used_id = 1; rs2_id = 5;
        tick("mispredict_over_load_use");
        idle_inputs();
        tick("after_mispredict");

        // DIV with result 5 cycles after start
        md_start_ex = 1; mispredict_ex = 1;
        tick("div_start");
        mispredict_ex = 0;
        for (int i = 0; i < 4; i++) tick("div_wait");
        md_done = 1;
        tick("div_done");
        idle_inputs();
        tick("after_div");

        // 0-cycle MUL result
        md_start_ex = 1; md_done = 1;
        tick("mul_zero_cycle");
        idle_inputs();

        // timeout: no md_done ever arrives
        md_start_ex = 1;
        tick("to_start");
        md_start_ex = 0;
        for (int i = 0; i < MD_TO; i++) tick("to_wait");
        tick("to_after1");
        tick("to_after2");
        check("timeout_sticky", 64'(md_timeout), 64'(1));

        // memory wait for 3 cycles, released on the 4th
        dmem_req_mem = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) tick("mem_wait");
        dmem_ready = 1;
        tick("mem_release");
        idle_inputs();
        tick("after_mem");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs1_id        = 5'($urandom_range(0, 7));
            rs2_id        = 5'($urandom_range(0, 7));
            rd_ex         = 5'($urandom_range(0, 7));
            rs1_used_id   = 1'($urandom_range(0, 1));
            rs2_used_id   = 1'($urandom_range(0, 1));
            mem_read_ex   = 1'($urandom_range(0, 1));
            mispredict_ex = ($urandom_range(0, 5) == 0);
            md_start_ex   = ($urandom_range(0, 7) == 0);
            md_done       = ($urandom_range(0, 9) == 0);
            dmem_req_mem  = ($urandom_range(0, 3) == 0);
            dmem_ready    = ($urandom_range(0, 3) != 0);
            tick("random");
        end
        idle_inputs();
        for (int i = 0; i < MD_TO + 2; i++) tick("drain");

        // asynchronous reset in the middle of MD_WAIT
        md_start_ex = 1;
        tick("rst_md_start");
        md_start_ex = 0;
        tick("rst_md_wait");
        #2 rst_n = 0;
        #1;
        check("async_rst_outputs", 64'(obs), 64'(0));
        check("async_rst_timeout", 64'(md_timeout), 64'(0));
        check("async_rst_stall", 64'(stall_cycles), 64'(0));
        check("async_rst_flush", 64'(flush_events), 64'(0));
        m_mem = 0; m_age = -1; m_to = 0; m_stall = '0; m_flush = '0;
        tick("held_reset");
        rst_n = 1;
        tick("post_reset");
        mispredict_ex = 1;
        tick("post_reset_mispredict");
        idle_inputs();
        tick("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
